// File: rtl/dct2d_row_col_sched.sv
// Row/column scheduler for an 8x8 2-D DCT that time-shares one 8-point 1-D core.
// Rows pass through the core into a transpose buffer; buffer columns then pass through the core to m_*.
module dct2d_row_col_sched #(
    parameter int W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [7:0][W-1:0]   s_data,
    output logic                core_in_valid,
    input  logic                core_in_ready,
    output logic [7:0][W-1:0]   core_in,
    input  logic                core_out_valid,
    output logic                core_out_ready,
    input  logic [7:0][W-1:0]   core_out,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [7:0][W-1:0]   m_data,
    output logic                m_last,
    output logic                busy,
    output logic                err,
    output logic                o_dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready; a valid
    // source holds its payload until accepted, and ready never waits on the same-side valid.
    typedef enum logic {
        ST_ROW = 1'b0,
        ST_COL = 1'b1
    } state_t;

    state_t           r_state;
    logic [3:0]       r_iss_cnt;
    logic [3:0]       r_rcv_cnt;
    logic             r_busy;
    logic             r_err;
    logic [W-1:0]     r_buf [8][8];

    logic             w_in_row;
    logic             w_iss_open;
    logic             w_pending;
    logic             w_rcv_last;
    logic             w_ci_hs;
    logic             w_co_hs;
    logic             w_m_hs;
    logic             w_s_hs;
    logic             w_row_wr;
    logic [7:0][W-1:0] w_col_vec;

    assign w_in_row   = (r_state == ST_ROW);
    assign w_iss_open = (r_iss_cnt < 4'd8);
    assign w_pending  = (r_rcv_cnt < r_iss_cnt);
    assign w_rcv_last = (r_rcv_cnt == 4'd7);

    always_comb begin
        w_col_vec = '0;
        for (int i = 0; i < 8; i++) begin
            w_col_vec[i] = r_buf[i][r_iss_cnt[2:0]];
        end
    end

    assign s_ready        = !rst && w_in_row && core_in_ready && w_iss_open;
    assign core_in_valid  = !rst && w_iss_open && (!w_in_row || s_valid);
    assign core_in        = w_in_row ? s_data : w_col_vec;
    assign core_out_ready = !rst && (w_in_row || m_ready);
    assign m_valid        = !rst && !w_in_row && core_out_valid;
    assign m_data         = core_out;
    assign m_last         = !w_in_row && w_rcv_last;
    assign busy           = r_busy;
    assign err            = r_err;
    assign o_dbg_state    = r_state;

    assign w_ci_hs = core_in_valid && core_in_ready;
    assign w_co_hs = core_out_valid && core_out_ready;
    assign w_m_hs  = m_valid && m_ready;
    assign w_s_hs  = s_valid && s_ready;
    // A row result with nothing outstanding is consumed but neither stored nor counted,
    // so a stray core beat cannot shift the rows of the next block.
    assign w_row_wr = w_in_row && w_co_hs && w_pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_ROW;
            r_iss_cnt <= 4'd0;
            r_rcv_cnt <= 4'd0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            if (core_out_valid && !w_pending) begin
                r_err <= 1'b1;
            end
            if (w_s_hs) begin
                r_busy <= 1'b1;
            end
            case (r_state)
                ST_ROW: begin
                    if (w_ci_hs) begin
                        r_iss_cnt <= r_iss_cnt + 4'd1;
                    end
                    if (w_row_wr) begin
                        if (w_rcv_last) begin
                            r_state   <= ST_COL;
                            r_iss_cnt <= 4'd0;
                            r_rcv_cnt <= 4'd0;
                        end else begin
                            r_rcv_cnt <= r_rcv_cnt + 4'd1;
                        end
                    end
                end
                ST_COL: begin
                    if (w_ci_hs) begin
                        r_iss_cnt <= r_iss_cnt + 4'd1;
                    end
                    if (w_m_hs) begin
                        if (w_rcv_last) begin
                            r_state   <= ST_ROW;
                            r_iss_cnt <= 4'd0;
                            r_rcv_cnt <= 4'd0;
                            r_busy    <= 1'b0;
                        end else begin
                            r_rcv_cnt <= r_rcv_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_ROW;
                end
            endcase
        end
    end

    // Transpose buffer: row rcv_cnt is written in ROW, columns are read in COL.
    always_ff @(posedge clk) begin
        if (w_row_wr) begin
            for (int j = 0; j < 8; j++) begin
                r_buf[r_rcv_cnt[2:0]][j] <= core_out[j];
            end
        end
    end

endmodule

// File: doc/dct2d_row_col_sched.md
# dct2d_row_col_sched

Scheduler that computes an 8x8 2-D DCT by time-sharing one 8-point 1-D DCT core (valid/ready on both sides, 8 lanes of W bits) between a row pass and a column pass. It accepts one block row per beat from upstream, routes rows through the core into an internal 8x8 transpose buffer, then feeds the buffer's columns through the same core and forwards the results downstream. It sits between the block fetcher and the quantiser in the compression pipeline. It does no arithmetic on sample values.

## Interface
Parameters:
- W, 32, lane width in bits (core in/out lanes, buffer words)

Ports:
- clk  in  1  clock, all logic rising-edge
- rst  in  1  reset, synchronous, active-high
- s_valid  in  1  upstream row valid
- s_ready  out  1  upstream row accepted when s_valid&&s_ready
- s_data  in  8xW  row lanes, s_data[j] = sample (r,j)
- core_in_valid  out  1  vector to 1-D core valid
- core_in_ready  in  1  core accepts vector
- core_in  out  8xW  vector to core (core in0..in7)
- core_out_valid  in  1  core result valid
- core_out_ready  out  1  scheduler accepts core result
- core_out  in  8xW  core result (core out0..out7)
- m_valid  out  1  downstream column result valid
- m_ready  in  1  downstream accepts
- m_data  out  8xW  column result lanes
- m_last  out  1  high on 8th (final) column beat of a block
- busy  out  1  high from first row accepted until last column accepted
- err  out  1  sticky: core result arrived with no outstanding issue

## Operation
- State: ROW (reset state), COL. Counters iss_cnt, rcv_cnt (0..8), 4 bits each. busy and err are registers.
- ROW:
  - core_in = s_data.
  - core_in_valid = s_valid && iss_cnt<8.
  - s_ready = core_in_ready && iss_cnt<8.
  - Each core_in handshake increments iss_cnt.
  - core_out_ready = 1. Each result handshake writes buf[rcv_cnt][j] = core_out[j] for j = 0..7, then increments rcv_cnt.
  - Handshake with rcv_cnt==7: next state COL, both counters cleared.
- COL:
  - s_ready = 0.
  - core_in[i] = buf[i][iss_cnt].
  - core_in_valid = iss_cnt<8. Each core_in handshake increments iss_cnt.
  - m_data = core_out, m_valid = core_out_valid, core_out_ready = m_ready. Results pass through combinationally, no storage.
  - m_last = (rcv_cnt==7).
  - Each m handshake increments rcv_cnt.
  - Handshake with rcv_cnt==7: next state ROW, counters cleared, busy cleared.
- Output order is column-major: beat c lane k = 2-D coefficient (k,c).
- busy sets on first s handshake of a block.
- err sets when core_out_valid=1 and rcv_cnt>=iss_cnt. That result is still consumed. Only rst clears err.
- Simultaneous issue and result in one cycle: both counters update; the buffer write and any column read never target the same phase.
- Blocks do not overlap: the next block's rows stall (s_ready=0) for the whole COL phase.
- Reset:
  - state ROW, counters 0, busy 0, err 0.
  - While rst=1: s_ready, core_in_valid, core_out_ready, m_valid forced 0.
  - Buffer contents are not reset.
  - Reset mid-block discards the block. The core must be reset by the same rst.

## Timing
- Valid/ready handshake rules:
  - Transfer occurs when valid&&ready at a rising edge.
  - The scheduler holds core_in_valid and core_in stable until accepted.
  - It never drops m_valid without m_ready, because it mirrors core_out_valid, which the core holds.
- s→core_in and core_out→m are combinational paths, zero added latency. The only registers are state, counters, flags and buffer.
- With a core of fixed latency L, throughput 1/cycle, no backpressure, first row accepted at cycle 0:
  - Rows accepted cycles 0–7; results 0–7 return at cycles L..7+L.
  - COL from cycle 8+L; column issues at 8+L..15+L.
  - m beats at 8+2L..15+2L, m_last at 15+2L.
  - ROW again at 16+2L; s_ready may rise that cycle.
- Block period without stalls: 16+2L cycles.
- A row-pass result written at edge t is readable as a column vector from cycle t+1.

## Test plan
- Identity core stub (L=3, core_out = core_in). Input row r lane j = 16r+j. Expected: 8 m beats, beat c lane k = 16k+c. m_last only on beat 7. First m_valid at cycle 14, last at 21, s_ready high at 22. busy low at 22. err 0.
- Back-to-back blocks: two blocks held on s_valid continuously. Expected: s_ready=0 from cycle 8 through 21, second block's row 0 accepted at cycle 22, both outputs correct.
- Backpressure: m_ready toggling 1,0,1,0 and core_in_ready low every 3rd cycle. Expected: identical data/order to test 1, no lost or duplicated beats, core_in stable while stalled.
- Reset mid-COL: assert rst for 1 cycle after the 3rd m beat, then send a fresh block. Expected: all valids/readies 0 during rst, busy=0, next block output complete and correct, err 0.
- Spurious core result: pulse core_out_valid with no issue in idle ROW. Expected: err=1 next cycle, stays 1 through the following block, cleared only by rst.
